iter_divider: RTL and testbench

- Multi-cycle 32-bit integer divider in the execute stage.
- Consumes two operands read from the triple-port register file and produces quotient and remainder for the writeback mux.
- Holds the pipeline through `stall` until the result is ready.
- Signed mode uses Euclidean semantics (remainder always non-negative), matching Oberon DIV/MOD.

---
 rtl/iter_divider.sv | 129 ++++++++++++
 tb/tb_iter_divider.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider: one quotient bit per cycle, then a sign/Euclidean
// fix-up step. Signed mode keeps the remainder non-negative (Oberon DIV/MOD).
module iter_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             u,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             stall,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem,
   output logic             divz,
   output logic [1:0]       dbg_state
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state, state_nx;

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] r, q, ay, xraw;
   logic             sx, sy, yz;

   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] diff;
   logic             fix_neg;
   logic [WIDTH-1:0] qm, rm, qf;

   // Handshake: run is held while stall is high; stall drops only in DONE,
   // which is the single cycle where quot/rem/divz are fresh and the pipe advances.
   assign stall     = run && (state != DONE);
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (run) state_nx = BUSY;
         BUSY: begin
            if (!run)                          state_nx = IDLE;
            else if (cnt == CW'(WIDTH - 1))    state_nx = FIX;
         end
         FIX:  state_nx = run ? DONE : IDLE;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Extra top bits keep the trial subtraction's sign unambiguous.
   always_comb begin
      shifted = {r, q[WIDTH-1]};
      diff    = {1'b0, shifted} - {2'b00, ay};
   end

   // Euclidean correction: a negative dividend with a non-zero remainder rounds
   // the magnitude quotient up so the remainder lands in [0, |y|).
   always_comb begin
      fix_neg = sx && (r != '0);
      qm      = fix_neg ? q + WIDTH'(1) : q;
      rm      = fix_neg ? ay - r : r;
      qf      = (sx ^ sy) ? -qm : qm;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         r    <= '0;
         q    <= '0;
         ay   <= '0;
         xraw <= '0;
         sx   <= 1'b0;
         sy   <= 1'b0;
         yz   <= 1'b0;
         quot <= '0;
         rem  <= '0;
         divz <= 1'b0;
      end else begin
         case (state)
            IDLE: if (run) begin
               sx   <= x[WIDTH-1] & ~u;
               sy   <= y[WIDTH-1] & ~u;
               q    <= (x[WIDTH-1] & ~u) ? -x : x;
               ay   <= (y[WIDTH-1] & ~u) ? -y : y;
               xraw <= x;
               yz   <= (y == '0);
               r    <= '0;
               cnt  <= '0;
            end
            BUSY: begin
               cnt <= cnt + CW'(1);
               if (!diff[WIDTH+1]) begin
                  r <= diff[WIDTH-1:0];
                  q <= {q[WIDTH-2:0], 1'b1};
               end else begin
                  r <= shifted[WIDTH-1:0];
                  q <= {q[WIDTH-2:0], 1'b0};
               end
            end
            FIX: if (run) begin
               if (yz) begin
                  quot <= '1;
                  rem  <= xraw;
                  divz <= 1'b1;
               end else begin
                  quot <= qf;
                  rem  <= rm;
                  divz <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_iter_divider.sv
// Bench for iter_divider: directed plan cases plus random divides against an
// arithmetic Euclidean-division model, with a per-cycle output scoreboard.
module tb_iter_divider;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic        u;
   logic [31:0] x, y;
   logic        stall;
   logic [31:0] quot, rem;
   logic        divz;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;

   logic [64:0] exp_q[$];
   logic [64:0] held;
   bit          mon_en = 1'b0;

   iter_divider #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .run(run), .u(u), .x(x), .y(y),
      .stall(stall), .quot(quot), .rem(rem), .divz(divz), .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference: plain integer division, then Euclidean adjustment of the remainder.
   task automatic model(input logic [31:0] a, input logic [31:0] b, input bit uu,
                        output logic [31:0] q, output logic [31:0] r, output bit dz);
      longint xs, ys, qq, rr;
      if (b == 0) begin
         q = '1; r = a; dz = 1'b1;
      end else if (uu) begin
         q = a / b; r = a % b; dz = 1'b0;
      end else begin
         xs = longint'($signed(a));
         ys = longint'($signed(b));
         qq = xs / ys;
         rr = xs % ys;
         if (rr < 0) begin
            if (ys > 0) begin qq = qq - 1; rr = rr + ys; end
            else        begin qq = qq + 1; rr = rr - ys; end
         end
         q = qq[31:0]; r = rr[31:0]; dz = 1'b0;
      end
   endtask

   // Scoreboard: in the one stall-low cycle with run held, outputs must equal the
   // next queued result; every other cycle they must hold their last value.
   always @(negedge clk) begin
      if (rst) begin
         held = '0;
         exp_q.delete();
      end else if (mon_en) begin
         if (run && !stall) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", {quot, rem, divz}, held);
            end else begin
               held = exp_q.pop_front();
               chk("result", {quot, rem, divz}, held);
            end
         end else begin
            chk("hold", {quot, rem, divz}, held);
         end
      end
   end

   // Driver: called just after a rising edge with the DUT in IDLE.
   task automatic do_div(input logic [31:0] a, input logic [31:0] b, input bit uu, input bit keep);
      logic [31:0] eq, er;
      bit          ed;
      int          cyc;
      bit          seen;
      model(a, b, uu, eq, er, ed);
      exp_q.push_back({eq, er, ed});
      x = a; y = b; u = uu; run = 1'b1;
      cyc = 0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (!stall) seen = 1'b1;
         else begin
            cyc++;
            if (cyc == 3) begin x = $urandom; y = $urandom; end
         end
      end
      chk("stall_cycles", 65'(cyc), 65'd34);
      @(posedge clk); #1;
      if (!keep) run = 1'b0;
   endtask

   task automatic lit_div(input logic [31:0] a, input logic [31:0] b, input bit uu,
                          input logic [31:0] eq, input logic [31:0] er, input bit ed);
      logic [31:0] mq, mr;
      bit          md;
      model(a, b, uu, mq, mr, md);
      chk("model_pin", {mq, mr, md}, {eq, er, ed});
      do_div(a, b, uu, 1'b0);
   endtask

   initial begin
      logic [31:0] ra, rb;
      rst = 1'b1; run = 1'b0; u = 1'b0; x = '0; y = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_outputs", {quot, rem, divz}, 65'd0);
      chk("reset_state", 65'(dbg_state), 65'd0);
      chk("reset_stall", 65'(stall), 65'd0);
      mon_en = 1'b1;
      @(posedge clk); #1;

      lit_div(32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0);
      lit_div(-32'sd7, 32'd2,  1'b0, 32'hFFFFFFFC, 32'd1, 1'b0);
      lit_div(-32'sd7, -32'sd2, 1'b0, 32'd4, 32'd1, 1'b0);
      lit_div(32'd7, -32'sd2,  1'b0, 32'hFFFFFFFD, 32'd1, 1'b0);
      lit_div(-32'sd8, 32'd2,  1'b0, 32'hFFFFFFFC, 32'd0, 1'b0);
      lit_div(32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 32'd0, 1'b0);
      lit_div(32'hFFFFFFFF, 32'd1, 1'b1, 32'hFFFFFFFF, 32'd0, 1'b0);
      lit_div(32'd123, 32'd0, 1'b1, 32'hFFFFFFFF, 32'd123, 1'b1);
      lit_div(32'd10, 32'd3, 1'b1, 32'd3, 32'd1, 1'b0);
      lit_div(32'd123, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd123, 1'b1);
      lit_div(32'd10, 32'd3, 1'b0, 32'd3, 32'd1, 1'b0);

      // back-to-back with run held across both
      do_div(32'd50, 32'd5, 1'b1, 1'b1);
      do_div(32'd9, 32'd4, 1'b1, 1'b0);

      // flush in BUSY cycle 10
      x = 32'd1000; y = 32'd3; u = 1'b1; run = 1'b1;
      repeat (11) @(posedge clk);
      #1;
      chk("abort_busy", 65'(dbg_state), 65'd1);
      run = 1'b0;
      @(posedge clk); #1;
      chk("abort_idle", 65'(dbg_state), 65'd0);
      chk("abort_stall", 65'(stall), 65'd0);
      do_div(32'd1000, 32'd3, 1'b1, 1'b0);

      // reset mid-BUSY
      x = 32'd77; y = 32'd5; u = 1'b1; run = 1'b1;
      repeat (6) @(posedge clk);
      #1 rst = 1'b1; run = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      chk("rst_outputs", {quot, rem, divz}, 65'd0);
      chk("rst_state", 65'(dbg_state), 65'd0);

      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 5))
            0: ra = 32'h80000000;
            1: ra = 32'hFFFFFFFF;
            2: ra = $urandom_range(0, 50);
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0: rb = 32'd0;
            1: rb = 32'hFFFFFFFF;
            2: rb = $urandom_range(1, 20);
            3: rb = -($urandom_range(1, 20));
            default: rb = $urandom;
         endcase
         do_div(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      run = 1'b0;
      repeat (3) @(posedge clk);
      chk("queue_drained", 65'(exp_q.size()), 65'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
